// File: rtl/aes_core_arbiter.sv
// Round-robin front end for a shared, non-stallable AES-128 pipeline.
// Credit-based admission keeps the response FIFO from overflowing.
module aes_core_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 21,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*128-1:0]     req_data,
  input  logic [NUM_REQ*128-1:0]     req_key,
  output logic [127:0]               core_state,
  output logic [127:0]               core_key,
  input  logic [127:0]               core_out,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [127:0]               resp_data,
  output logic [$clog2(NUM_REQ)-1:0] resp_id
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int OCCW = $clog2(FIFO_DEPTH + 1);
  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [NUM_REQ-1:0] gnt_s;
  logic               gnt_any_s;
  logic [IDW-1:0]     gnt_id_s;
  logic [IDW:0]       cand_s;
  logic               hit_s;
  logic [127:0]       lane_data_s;
  logic [127:0]       lane_key_s;
  logic               push_s;
  logic               pop_s;
  logic               resp_valid_s;

  logic [OCCW-1:0]    occ_q, occ_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [127:0]       state_q, state_d;
  logic [127:0]       key_q, key_d;
  logic [LATENCY:0]   tag_vld_q;
  logic [IDW-1:0]     tag_id_q [LATENCY+1];
  logic [127:0]       fifo_data_q [FIFO_DEPTH];
  logic [IDW-1:0]     fifo_id_q [FIFO_DEPTH];
  logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCCW-1:0]    cnt_q, cnt_d;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Round-robin search from last_q+1, gated by outstanding-block credit
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_id_s  = last_q;
    cand_s    = '0;
    hit_s     = 1'b0;
    if (occ_q < OCCW'(FIFO_DEPTH)) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand_s    = {1'b0, last_q} + (IDW+1)'(k);
        cand_s    = (cand_s >= (IDW+1)'(NUM_REQ)) ? cand_s - (IDW+1)'(NUM_REQ) : cand_s;
        hit_s     = !gnt_any_s && req_valid[cand_s[IDW-1:0]];
        gnt_id_s  = hit_s ? cand_s[IDW-1:0] : gnt_id_s;
        gnt_any_s = gnt_any_s | hit_s;
      end
    end else begin
      gnt_any_s = 1'b0;
    end
    gnt_s = gnt_any_s ? (NUM_REQ'(1) << gnt_id_s) : '0;
  end

  // One-hot lane select of plaintext and key
  always_comb begin
    lane_data_s = '0;
    lane_key_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lane_data_s = lane_data_s | (gnt_s[i] ? req_data[128*i +: 128] : 128'd0);
      lane_key_s  = lane_key_s  | (gnt_s[i] ? req_key[128*i +: 128]  : 128'd0);
    end
  end

  // Next-state for issue registers, credit counter and FIFO bookkeeping
  always_comb begin
    resp_valid_s = (cnt_q != '0);
    pop_s        = resp_valid_s & resp_ready;
    push_s       = tag_vld_q[LATENCY];
    state_d      = gnt_any_s ? lane_data_s : state_q;
    key_d        = gnt_any_s ? lane_key_s : key_q;
    last_d       = gnt_any_s ? gnt_id_s : last_q;
    wr_ptr_d     = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({gnt_any_s, pop_s})
      2'b10:   occ_d = occ_q + OCCW'(1);
      2'b01:   occ_d = occ_q - OCCW'(1);
      default: occ_d = occ_q;
    endcase
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + OCCW'(1);
      2'b01:   cnt_d = cnt_q - OCCW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Issue registers, credit counter and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= '0;
      last_q   <= IDW'(NUM_REQ - 1);
      state_q  <= '0;
      key_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      last_q   <= last_d;
      state_q  <= state_d;
      key_q    <= key_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag pipe: stage 0 pairs with the issue register, the last stage with core_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int j = 0; j <= LATENCY; j++) begin
        tag_id_q[j] <= '0;
      end
    end else begin
      tag_vld_q   <= {tag_vld_q[LATENCY-1:0], gnt_any_s};
      tag_id_q[0] <= gnt_id_s;
      for (int j = 1; j <= LATENCY; j++) begin
        tag_id_q[j] <= tag_id_q[j-1];
      end
    end
  end

  // FIFO storage; contents are only observed through the valid-gated head
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_q[wr_ptr_q] <= core_out;
      fifo_id_q[wr_ptr_q]   <= tag_id_q[LATENCY];
    end
  end

  assign req_ready  = gnt_s;
  assign core_state = state_q;
  assign core_key   = key_q;
  assign resp_valid = resp_valid_s;
  assign resp_data  = resp_valid_s ? fifo_data_q[rd_ptr_q] : 128'd0;
  assign resp_id    = resp_valid_s ? fifo_id_q[rd_ptr_q] : '0;

endmodule
